input_conditioner: RTL
======================

# input_conditioner

Conditions the four raw push-button inputs (SW1–SW4) before they reach the player control stage. Each switch is synchronised and debounced. Presses are then converted into single-cycle, direction-encoded move requests with hold-to-repeat. Downstream, player control consumes one move per MOVE_VALID pulse and no longer sees raw bouncing switch levels. Debounced levels are also exported for LED or status use.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive cycles a synchronised level must differ from the stable level before it is accepted (10 ms at 25 MHz). Minimum 1.
- REPEAT_DELAY, 12500000: cycles from the first move pulse of a held switch to its first repeat pulse (0.5 s). Minimum 2.
- REPEAT_PERIOD, 5000000: cycles between subsequent repeat pulses while held (0.2 s). Minimum 2.

Ports:
- CLK  in  1  system clock; all state is on the rising edge.
- RST_N  in  1  asynchronous active-low reset, one clock; release is synchronous to CLK upstream.
- SW1  in  1  raw Up button, active-high, asynchronous.
- SW2  in  1  raw Down button, active-high, asynchronous.
- SW3  in  1  raw Left button, active-high, asynchronous.
- SW4  in  1  raw Right button, active-high, asynchronous.
- PRESSED  out  4  debounced levels; bit0 = SW1 … bit3 = SW4.
- MOVE_VALID  out  1  one-cycle move request strobe.
- MOVE_DIR  out  2  direction, valid while MOVE_VALID is high: 00 up, 01 down, 10 left, 11 right. Holds its last value otherwise.

## Operation
- Synchroniser: two flops per switch, both reset to 0.
- Debouncer, per switch:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - While the synchronised level differs from the stable level, the counter increments. On the edge it would reach DEBOUNCE_CYCLES, the stable level toggles and the counter clears.
  - Any cycle in which the synchronised level equals the stable level clears the counter.
  - Stable levels drive PRESSED directly.
- Press event: a rising edge of a stable level, detected against a one-cycle-delayed copy of that level.
- Simultaneous press events in the same cycle: priority is SW1 > SW2 > SW3 > SW4. Lower-priority events are discarded and never replayed.
- Move FSM: one shared timer, width clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
  - IDLE: a press event registers MOVE_VALID=1, latches MOVE_DIR to the winning switch, clears the timer and goes to HOLD.
  - HOLD: if the latched switch's stable level is 0, go to IDLE with no pulse. Otherwise, when the timer reaches REPEAT_DELAY-1, pulse with the same MOVE_DIR, clear the timer and go to REPEAT. Otherwise increment the timer.
  - REPEAT: release goes to IDLE. Otherwise, when the timer reaches REPEAT_PERIOD-1, pulse and clear the timer. Otherwise increment the timer.
  - A press event on any switch while in HOLD or REPEAT preempts the current hold. It pulses the new direction, latches it, clears the timer and enters HOLD. Release of the old switch is then ignored.
  - Preemption is evaluated before the release and timer checks in the same cycle.
- MOVE_VALID is never high on two consecutive cycles.

## Timing
- Reset (asynchronous, RST_N=0) sets:
  - synchroniser flops, stable levels and counters to 0;
  - PRESSED=0000, MOVE_VALID=0, MOVE_DIR=00;
  - FSM to IDLE, timer to 0.
- A switch held through reset release is treated as a new press after the full debounce interval.
- Press latency, for a clean press with the first sampling edge counted as edge 1:
  - edges 1–2: synchroniser;
  - edges 3 to DEBOUNCE_CYCLES+2: debounce count;
  - edge DEBOUNCE_CYCLES+2: PRESSED bit rises;
  - edge DEBOUNCE_CYCLES+3: MOVE_VALID rises, high for that one cycle.
- Release latency matches the press path: PRESSED falls at edge DEBOUNCE_CYCLES+2 after the first low sample.
- Repeat cadence: with the first pulse in cycle P, repeats occur in cycles P+REPEAT_DELAY, then P+REPEAT_DELAY+k·REPEAT_PERIOD.
- Bounce shorter than DEBOUNCE_CYCLES consecutive cycles never changes PRESSED and never produces a pulse.
- Reset asserted mid-debounce or mid-repeat aborts immediately; no pulse is emitted during or on release of reset.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press: SW3 held high from edge 1 for 8 cycles. Required: PRESSED=0100 from edge 6; one MOVE_VALID at edge 7 with MOVE_DIR=10; no further pulse.
- Bounce: SW1 toggles high 3 cycles / low 1 cycle, repeated 5 times. Required: PRESSED stays 0000; MOVE_VALID never asserts.
- Hold-repeat: SW2 held for 30 cycles after its first pulse at cycle P. Required: pulses at P, P+10, P+13, P+16 and every +3 cycles, all with MOVE_DIR=01; pulses stop within 6 cycles of release.
- Simultaneous press: SW1, SW2 and SW4 rise on the same edge. Required: exactly one pulse, MOVE_DIR=00; no later pulse for SW2 or SW4 while all are held, until the SW1 repeat timing.
- Preemption: SW4 held in REPEAT, then SW3 pressed. Required: a pulse with MOVE_DIR=10 at SW3's press edge, the next repeat 10 cycles later, and MOVE_DIR=11 never seen again.
- Reset mid-operation: RST_N=0 for 2 cycles during REPEAT with SW2 still held. Required: all outputs 0 immediately; after release, PRESSED=0010 at edge 6 and a pulse at edge 7.

Source files
------------

// File: rtl/input_conditioner.sv
// Conditions four raw push-buttons: two-flop synchroniser, per-switch debounce,
// and a shared move FSM producing one-cycle direction strobes with hold-to-repeat.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       SW1,
    input  logic       SW2,
    input  logic       SW3,
    input  logic       SW4,
    output logic [3:0] PRESSED,
    output logic       MOVE_VALID,
    output logic [1:0] MOVE_DIR
);

    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(RMAX);

    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_REPEAT
    } state_t;

    logic [3:0]          sw_raw;
    logic [3:0]          sync1_q;
    logic [3:0]          sync2_q;
    logic [3:0]          stable_q;
    logic [3:0]          stable_d;
    logic [3:0]          stable_dly_q;
    logic [3:0][CW-1:0]  cnt_q;
    logic [3:0][CW-1:0]  cnt_d;
    logic [3:0]          press_ev;
    logic                press_any;
    logic [1:0]          press_win;

    state_t              state_q;
    logic [TW-1:0]       timer_q;
    logic                valid_q;
    logic [1:0]          dir_q;
    logic                pend_q;
    logic [1:0]          pend_dir_q;

    assign sw_raw = {SW4, SW3, SW2, SW1};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sw_raw;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
        end
    end

    // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    stable_d[i] = ~stable_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    assign press_ev  = stable_q & ~stable_dly_q;
    assign press_any = |press_ev;

    always_comb begin
        if (press_ev[0]) begin
            press_win = 2'd0;
        end else if (press_ev[1]) begin
            press_win = 2'd1;
        end else if (press_ev[2]) begin
            press_win = 2'd2;
        end else begin
            press_win = 2'd3;
        end
    end

    // A press landing right after a strobe is deferred one cycle so strobes never abut.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            valid_q    <= 1'b0;
            dir_q      <= 2'd0;
            pend_q     <= 1'b0;
            pend_dir_q <= 2'd0;
        end else begin
            valid_q <= 1'b0;
            if (press_any && !valid_q) begin
                valid_q <= 1'b1;
                dir_q   <= press_win;
                timer_q <= '0;
                state_q <= S_HOLD;
                pend_q  <= 1'b0;
            end else if (press_any) begin
                pend_q     <= 1'b1;
                pend_dir_q <= press_win;
            end else if (pend_q) begin
                valid_q <= 1'b1;
                dir_q   <= pend_dir_q;
                timer_q <= '0;
                state_q <= S_HOLD;
                pend_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        timer_q <= timer_q;
                    end
                    S_HOLD: begin
                        if (!stable_q[dir_q]) begin
                            state_q <= S_IDLE;
                        end else if (timer_q == DLY_LAST) begin
                            valid_q <= 1'b1;
                            timer_q <= '0;
                            state_q <= S_REPEAT;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    S_REPEAT: begin
                        if (!stable_q[dir_q]) begin
                            state_q <= S_IDLE;
                        end else if (timer_q == PER_LAST) begin
                            valid_q <= 1'b1;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign PRESSED    = stable_q;
    assign MOVE_VALID = valid_q;
    assign MOVE_DIR   = dir_q;

endmodule
